// File: rtl/dpy_scan_pwm.sv
// Multiplexed seven-segment scanner with PWM dimming, blinking and leading-zero blanking.
// Outputs are registered one cycle after the scan, PWM, blink and shadow state they depend on.
module dpy_scan_pwm #(
  parameter int unsigned DIGIT_CNT  = 8,
  parameter int unsigned SCAN_DIV   = 12500,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned BLINK_LOG2 = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*DIGIT_CNT-1:0] number,
  input  logic [DIGIT_CNT-1:0]   dp,
  input  logic [DIGIT_CNT-1:0]   blink_mask,
  input  logic                   load,
  input  logic                   blank_lz,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [DIGIT_CNT-1:0]   digit_sel,
  output logic [7:0]             segment,
  output logic                   frame_done
);

  localparam int unsigned IDX_W = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]    LAST_SLOT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    LAST_DIGIT = IDX_W'(DIGIT_CNT - 1);
  localparam logic [PWM_BITS-1:0] PWM_FULL   = {PWM_BITS{1'b1}};

  logic [4*DIGIT_CNT-1:0] number_q;
  logic [DIGIT_CNT-1:0]   dp_q;
  logic [DIGIT_CNT-1:0]   blink_q;
  logic [CNT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]       digit_idx;
  logic [PWM_BITS-1:0]    pwm_cnt;
  logic [BLINK_LOG2-1:0]  blink_cnt;
  logic                   wrap_q;

  logic       slot_wrap_c;
  logic [3:0] nibble_c;
  logic       dp_bit_c;
  logic       blink_bit_c;
  logic       lz_c;
  logic       upper_zero_c;
  logic       lit_c;
  logic       blank_c;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_wrap_c = (slot_cnt == LAST_SLOT);

  // Select the current digit's shadow fields; walk from the top to track "all zero from here up".
  always_comb begin
    nibble_c     = 4'h0;
    dp_bit_c     = 1'b0;
    blink_bit_c  = 1'b0;
    lz_c         = 1'b0;
    upper_zero_c = 1'b1;
    for (int i = int'(DIGIT_CNT) - 1; i >= 0; i--) begin
      upper_zero_c = upper_zero_c & (number_q[4*i +: 4] == 4'h0);
      if (digit_idx == IDX_W'(i)) begin
        nibble_c    = number_q[4*i +: 4];
        dp_bit_c    = dp_q[i];
        blink_bit_c = blink_q[i];
        lz_c        = blank_lz & upper_zero_c & (i > 0);
      end
    end
  end

  assign lit_c   = (brightness == PWM_FULL) || (pwm_cnt < brightness);
  assign blank_c = (blink_bit_c & blink_cnt[BLINK_LOG2-1]) | lz_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      number_q   <= '0;
      dp_q       <= '0;
      blink_q    <= '0;
      slot_cnt   <= '0;
      digit_idx  <= '0;
      pwm_cnt    <= '0;
      blink_cnt  <= '0;
      wrap_q     <= 1'b0;
      digit_sel  <= '0;
      segment    <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        number_q <= number;
        dp_q     <= dp;
        blink_q  <= blink_mask;
      end
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      blink_cnt <= blink_cnt + BLINK_LOG2'(1);
      if (slot_wrap_c) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end
      // wrap_q marks the first slot cycle of digit 0 after a completed scan
      wrap_q     <= slot_wrap_c && (digit_idx == LAST_DIGIT);
      frame_done <= wrap_q;
      digit_sel  <= lit_c ? (DIGIT_CNT'(1) << digit_idx) : '0;
      segment    <= (lit_c && !blank_c) ? {dp_bit_c, hex7(nibble_c)} : 8'h00;
    end
  end

endmodule

// File: tb/tb_dpy_scan_pwm.sv
// Scoreboard bench for dpy_scan_pwm: expected outputs come from a cycle-count based model
// and are queued by the driver, then popped by an independent monitor after each clock edge.
module tb_dpy_scan_pwm;

  localparam int unsigned D  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned PB = 2;
  localparam int unsigned BL = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   number;
  logic [3:0]    dp;
  logic [3:0]    blink_mask;
  logic          load;
  logic          blank_lz;
  logic [1:0]    brightness;
  logic [3:0]    digit_sel;
  logic [7:0]    segment;
  logic          frame_done;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: cycles since reset release plus the values the display should currently hold
  int          n;
  logic [15:0] num_m;
  logic [3:0]  dp_m;
  logic [3:0]  blk_m;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  dpy_scan_pwm #(
    .DIGIT_CNT (D),
    .SCAN_DIV  (S),
    .PWM_BITS  (PB),
    .BLINK_LOG2(BL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .number    (number),
    .dp        (dp),
    .blink_mask(blink_mask),
    .load      (load),
    .blank_lz  (blank_lz),
    .brightness(brightness),
    .digit_sel (digit_sel),
    .segment   (segment),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Display output expected for the cycle whose state is t cycles after reset release
  function automatic exp_t model(input int t, input logic [15:0] num, input logic [3:0] dpv,
                                 input logic [3:0] blk, input logic lz, input logic [1:0] br);
    exp_t       e;
    int         dg;
    logic [15:0] upper;
    logic [3:0] nib;
    logic       lit;
    logic       phase;
    logic       blank;
    dg    = (t / int'(S)) % int'(D);
    upper = num >> (4 * dg);
    nib   = upper[3:0];
    lit   = (br == 2'b11) || ((t % (1 << PB)) < int'(br));
    phase = ((t >> (BL - 1)) & 1) == 1;
    blank = (blk[dg] && phase) || (lz && dg > 0 && upper == 16'h0);
    e.fd  = (t > 0) && (t % int'(S * D) == 0);
    e.sel = 4'h0;
    e.seg = 8'h00;
    if (lit) begin
      e.sel = 4'(1) << dg;
      e.seg = blank ? 8'h00 : {dpv[dg], seg_tab[nib]};
    end
    return e;
  endfunction

  // Drive one cycle of inputs at a falling edge, queue its expected output, advance the model
  task automatic step(input logic ld, input logic [15:0] nv, input logic [3:0] dv,
                      input logic [3:0] bv, input logic lzv, input logic [1:0] brv);
    load       = ld;
    number     = nv;
    dp         = dv;
    blink_mask = bv;
    blank_lz   = lzv;
    brightness = brv;
    exp_q.push_back(model(n, num_m, dp_m, blk_m, lzv, brv));
    if (ld) begin
      num_m = nv;
      dp_m  = dv;
      blk_m = bv;
    end
    n++;
    @(negedge clock);
  endtask

  task automatic run(input int k, input logic lzv, input logic [1:0] brv);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0, 4'h0, 4'h0, lzv, brv);
  endtask

  task automatic run_random(input int k);
    logic       lz;
    logic [1:0] br;
    lz = 1'b0;
    br = 2'b11;
    for (int i = 0; i < k; i++) begin
      if ($urandom_range(0, 19) == 0) lz = 1'($urandom);
      if ($urandom_range(0, 19) == 0) br = 2'($urandom);
      step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom), 4'($urandom), lz, br);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (digit_sel !== 4'h0 || segment !== 8'h00 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got sel=%b seg=%h fd=%b, want sel=0000 seg=00 fd=0",
               tag, digit_sel, segment, frame_done);
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
    n     = 0;
    num_m = 16'h0;
    dp_m  = 4'h0;
    blk_m = 4'h0;
  endtask

  // Monitor: every cycle the DUT presents a registered output, compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({digit_sel, segment, frame_done} !== e) begin
          errors++;
          $display("FAIL scan_out @%0t: got sel=%b seg=%h fd=%b, want sel=%b seg=%h fd=%b",
                   $time, digit_sel, segment, frame_done, e.sel, e.seg, e.fd);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    number     = 16'h0;
    dp         = 4'h0;
    blink_mask = 4'h0;
    blank_lz   = 1'b0;
    brightness = 2'b11;
    n          = 0;
    num_m      = 16'h0;
    dp_m       = 4'h0;
    blk_m      = 4'h0;
    #1;
    check_reset_outputs("reset_initial");
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_held");
    release_reset();

    // Basic scan with full brightness
    step(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0, 2'b11);
    run(64, 1'b0, 2'b11);

    // Leading-zero blanking on and off
    step(1'b1, 16'h0005, 4'h0, 4'h0, 1'b1, 2'b11);
    run(32, 1'b1, 2'b11);
    run(32, 1'b0, 2'b11);

    // Dimming
    run(32, 1'b0, 2'b01);
    run(32, 1'b0, 2'b00);
    run(16, 1'b0, 2'b10);

    // Blink on digit 2 and decimal point on digit 0
    step(1'b1, 16'h12AF, 4'b0001, 4'b0100, 1'b0, 2'b11);
    run(64, 1'b0, 2'b11);

    // Load landing on the last cycle of a slot
    while (n % int'(S) != int'(S) - 1) run(1, 1'b0, 2'b11);
    step(1'b1, 16'h3C7E, 4'b1010, 4'h0, 1'b0, 2'b11);
    run(8, 1'b0, 2'b11);
    while (n % int'(S) != int'(S) - 1) run(1, 1'b0, 2'b11);
    step(1'b1, 16'hD4B6, 4'h0, 4'h0, 1'b0, 2'b11);
    run(8, 1'b0, 2'b11);

    run_random(400);

    // Reset in the middle of a frame, then scan restarts from digit 0 with cleared shadows
    while (n % int'(S * D) != 7) run(1, 1'b0, 2'b11);
    #1;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_async_mid");
    repeat (3) begin
      @(negedge clock);
      check_reset_outputs("reset_mid_held");
    end
    release_reset();
    run(40, 1'b0, 2'b11);
    run_random(300);

    @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpy_scan_pwm.md
DPY_SCAN_PWM -- requirements
Module: dpy_scan_pwm

Interface
REQ-001 SHALL have parameter DIGIT_CNT, default 8: number of seven-segment digits scanned.
REQ-002 SHALL have parameter SCAN_DIV, default 12500: clock cycles per digit slot; legal values are 2 or more.
REQ-003 SHALL have parameter PWM_BITS, default 4: width of the brightness control.
REQ-004 SHALL have parameter BLINK_LOG2, default 24: width of the free-running blink counter.
REQ-005 SHALL have port clock, input, 1: single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port number, input, 4*DIGIT_CNT: hex digits; nibble i drives digit i, with digit 0 least significant.
REQ-008 SHALL have port dp, input, DIGIT_CNT: decimal point request per digit.
REQ-009 SHALL have port blink_mask, input, DIGIT_CNT: marks each digit that blinks.
REQ-010 SHALL have port load, input, 1: one-cycle strobe that latches number, dp and blink_mask.
REQ-011 SHALL have port blank_lz, input, 1: enables leading-zero blanking.
REQ-012 SHALL have port brightness, input, PWM_BITS: duty control; all-ones means full on.
REQ-013 SHALL have port digit_sel, output, DIGIT_CNT: one-hot active-high digit enable, registered.
REQ-014 SHALL have port segment, output, 8: {dp,g,f,e,d,c,b,a}, active-high, registered.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each full scan.

Function
REQ-016 SHALL copy number, dp and blink_mask into shadow registers on the rising edge where load=1; the display reads only the shadows, so a new value is visible from the next cycle and never tears within one cycle.
REQ-017 SHALL run the slot counter 0..SCAN_DIV-1 and wrap; on wrap, the digit index advances 0..DIGIT_CNT-1 and wraps to 0.
REQ-018 SHALL pulse frame_done for exactly one cycle, on the cycle after the index wraps from DIGIT_CNT-1 to 0, aligned with the outputs for digit 0.
REQ-019 SHALL keep pwm_cnt as a free-running PWM_BITS-bit counter; a digit is lit when pwm_cnt < brightness, or always when brightness is all ones; brightness 0 keeps the display dark.
REQ-020 SHALL drive the blink phase from the MSB of the BLINK_LOG2 counter; when the phase is 1, digits whose shadow blink_mask bit is set are blanked.
REQ-021 SHALL apply leading-zero blanking when blank_lz=1: digit i (i>0) is blanked when shadow nibbles i..DIGIT_CNT-1 are all zero; digit 0 is never blanked by this rule.
REQ-022 SHALL decode hex to segments a-g as: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; bit 7 is the shadow dp bit.
REQ-023 SHALL, for a blanked digit (blink or leading zero), set segment=00 including dp, while digit_sel stays one-hot.
REQ-024 SHALL, when the PWM phase is off, set digit_sel=0 and segment=00.
REQ-025 SHALL register outputs with exactly one cycle of latency from the digit index, PWM state, blink state and shadow registers.
REQ-026 SHALL sample blank_lz and brightness live without shadowing; a change takes effect on the next cycle.
REQ-027 SHALL, when load is asserted on the same cycle the slot wraps, show the newly loaded value starting from the next digit displayed.

Reset
REQ-028 SHALL, while reset=1, immediately and asynchronously drive digit_sel=0, segment=00 and frame_done=0.
REQ-029 SHALL, while reset=1, clear the shadow registers, the slot counter, digit index, pwm_cnt and blink counter to 0.
REQ-030 SHALL, when reset is asserted mid-slot, abort the scan; after release the first visible digit is digit 0, with a full SCAN_DIV slot.

Verification (DIGIT_CNT=4, SCAN_DIV=4, PWM_BITS=2, BLINK_LOG2=5)
REQ-031 SHALL cover: release reset, pulse load with number=16'h12AF, dp=0, brightness=3 -> digit_sel steps 0001,0010,0100,1000 every 4 cycles with segment 71,77,5B,06, and frame_done pulses once per 16 cycles.
REQ-032 SHALL cover: number=16'h0005, blank_lz=1 -> segment=00 for digits 3..1 and 6D for digit 0; with blank_lz=0, digits 3..1 show 3F.
REQ-033 SHALL cover: brightness=1 -> digit_sel is nonzero on exactly 1 of every 4 cycles; brightness=0 -> digit_sel stays 0.
REQ-034 SHALL cover: blink_mask=4'b0100 -> digit 2 segment alternates between normal and 00 every 16 cycles while other digits are unaffected; dp=4'b0001 -> digit 0 shows bit 7 set.
REQ-035 SHALL cover: load of a new value on the cycle before the slot wraps -> the next slot shows the new nibble.
REQ-036 SHALL cover: reset asserted mid-frame -> outputs go to 0 in the same cycle, and after release digit 0 reappears with the shadow contents equal to 0 (segment 3F).
